serial_frame_rx: RTL

Downstream consumer of the counter/shift-register serial stage. It takes that stage's serial output bit stream, finds frame boundaries, and deserialises DATA_W data bits. It checks even parity and the stop bit, presents the received word in parallel with a one-cycle valid strobe, and keeps a wrap-around count of good frames.

---
 rtl/serial_pkg.sv | 17 +
 rtl/rx_bit_counter.sv | 30 +++
 rtl/serial_frame_rx.sv | 106 ++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame receiver.
// State encoding, frame bit levels and default widths.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } state_t;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam int   DATA_W_DEF = 8;
  localparam int   CNT_W_DEF  = 8;

endpackage

// File: rtl/rx_bit_counter.sv
// Data-bit counter for the frame receiver.
// Loadable up-counter with clear, enable and terminal count.
module rx_bit_counter #(
  parameter int           W  = 3,
  parameter logic [W-1:0] TC = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  input  logic         i_inc,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  // load wins over increment; terminal count flags last data bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_d;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == TC);

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start, LSB-first data, even parity, stop.
// Registered word, one-cycle status pulses, wrapping good-frame count.
module serial_frame_rx
  import serial_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              si,
  output logic [DATA_W-1:0] po,
  output logic              valid,
  output logic              par_err,
  output logic              frm_err,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);

  state_t             r_state;
  logic [DATA_W-1:0]  r_sh;
  logic [DATA_W-1:0]  r_po;
  logic               r_par;
  logic               r_valid;
  logic               r_par_err;
  logic               r_frm_err;
  logic [CNT_W-1:0]   r_cnt;

  logic w_load;
  logic w_inc;
  logic w_last;
  logic w_par_bad;

  assign w_load    = en && (r_state == IDLE);
  assign w_inc     = en && (r_state == DATA);
  assign w_par_bad = ^{r_sh, r_par};

  rx_bit_counter #(
    .W  (BW),
    .TC (LAST)
  ) u_bit_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_d    ('0),
    .i_inc  (w_inc),
    .o_tc   (w_last)
  );

  // frame FSM, shift register, parity/stop checks and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_sh      <= '0;
      r_po      <= '0;
      r_par     <= 1'b0;
      r_valid   <= 1'b0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_valid   <= 1'b0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
      if (en) begin
        unique case (r_state)
          IDLE: begin
            if (si == START_BIT) r_state <= DATA;
          end
          DATA: begin
            r_sh <= {si, r_sh[DATA_W-1:1]};
            if (w_last) r_state <= PAR;
          end
          PAR: begin
            r_par   <= si;
            r_state <= STOP;
          end
          STOP: begin
            if (si != STOP_BIT) begin
              r_frm_err <= 1'b1;
            end else if (w_par_bad) begin
              r_par_err <= 1'b1;
            end else begin
              r_po    <= r_sh;
              r_valid <= 1'b1;
              r_cnt   <= r_cnt + 1'b1;
            end
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign po        = r_po;
  assign valid     = r_valid;
  assign par_err   = r_par_err;
  assign frm_err   = r_frm_err;
  assign busy      = (r_state != IDLE);
  assign frame_cnt = r_cnt;

endmodule
